// File: rtl/bpsk_tx_scheduler.sv
// Round-robin scheduler sharing one BPSK symbol stream between a Hamming and a BCH encoder.
// Define BPSK_PREAMBLE_EN to prefix every frame with the +1,-1,+1,-1 preamble.
module bpsk_tx_scheduler #(
    parameter int HAM_N = 12,
    parameter int BCH_N = 15,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ham_valid,
    input  logic [HAM_N-1:0] ham_data,
    output logic             ham_ready,
    input  logic             bch_valid,
    input  logic [BCH_N-1:0] bch_data,
    output logic             bch_ready,
    output logic             sym_valid,
    output logic [1:0]       sym_data,
    input  logic             sym_ready,
    output logic             sym_last,
    output logic             sym_src,
    output logic             busy
);

    localparam int CW = $clog2(BCH_N + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [CW-1:0] ZERO_CW  = CW'(0);
    localparam logic [CW-1:0] HAM_LEN  = CW'(HAM_N);
    localparam logic [CW-1:0] BCH_LEN  = CW'(BCH_N);
    localparam logic [GW-1:0] ZERO_GW  = GW'(0);
    localparam logic [GW-1:0] ONE_GW   = GW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

`ifdef BPSK_PREAMBLE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2, ST_PRE = 2'd3} state_t;
    localparam logic [CW-1:0] PRE_LAST = CW'(3);
    localparam state_t AFTER_ACCEPT = ST_PRE;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;
    localparam state_t AFTER_ACCEPT = ST_SEND;
`endif
    localparam state_t AFTER_SEND = (GAP > 0) ? ST_GAP : ST_IDLE;

    state_t           state_r;
    state_t           state_s;
    logic             rr_ptr_r;
    logic [BCH_N-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    len_r;
    logic [GW-1:0]    gap_cnt_r;
    logic             src_r;

    logic grant_ham_s;
    logic grant_bch_s;
    logic accept_s;
    logic last_s;
    logic gap_done_s;

    // rr_ptr only breaks ties; a lone valid source always wins.
    assign grant_ham_s = ham_valid & (~bch_valid | ~rr_ptr_r);
    assign grant_bch_s = bch_valid & (~ham_valid | rr_ptr_r);
    assign accept_s    = (state_r == ST_IDLE) & (grant_ham_s | grant_bch_s);
    assign last_s      = (cnt_r == (len_r - ONE_CW));
    assign gap_done_s  = (gap_cnt_r == GAP_LAST);
    assign sym_src     = src_r;
    assign busy        = (state_r != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = AFTER_ACCEPT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef BPSK_PREAMBLE_EN
            ST_PRE: begin
                if (sym_ready && (cnt_r == PRE_LAST)) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_PRE;
                end
            end
`endif
            ST_SEND: begin
                if (sym_ready && last_s) begin
                    state_s = AFTER_SEND;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: readys only in IDLE, symbols only in PRE/SEND.
    always_comb begin
        ham_ready = 1'b0;
        bch_ready = 1'b0;
        sym_valid = 1'b0;
        sym_data  = 2'b00;
        sym_last  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ham_ready = grant_ham_s;
                bch_ready = grant_bch_s;
            end
`ifdef BPSK_PREAMBLE_EN
            ST_PRE: begin
                sym_valid = 1'b1;
                sym_data  = cnt_r[0] ? 2'b11 : 2'b01;
            end
`endif
            ST_SEND: begin
                sym_valid = 1'b1;
                sym_data  = shreg_r[0] ? 2'b11 : 2'b01;
                sym_last  = last_s;
            end
            default: begin
                sym_valid = 1'b0;
            end
        endcase
    end

    // Frame datapath: codeword latch, symbol/gap counters and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r  <= 1'b0;
            shreg_r   <= '0;
            cnt_r     <= ZERO_CW;
            len_r     <= ZERO_CW;
            gap_cnt_r <= ZERO_GW;
            src_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r   <= grant_bch_s ? bch_data
                                                 : {{(BCH_N-HAM_N){1'b0}}, ham_data};
                        len_r     <= grant_bch_s ? BCH_LEN : HAM_LEN;
                        cnt_r     <= ZERO_CW;
                        gap_cnt_r <= ZERO_GW;
                        src_r     <= grant_bch_s;
                        rr_ptr_r  <= ~grant_bch_s;
                    end
                end
`ifdef BPSK_PREAMBLE_EN
                ST_PRE: begin
                    if (sym_ready) begin
                        cnt_r <= (cnt_r == PRE_LAST) ? ZERO_CW : (cnt_r + ONE_CW);
                    end
                end
`endif
                ST_SEND: begin
                    if (sym_ready) begin
                        shreg_r <= {1'b0, shreg_r[BCH_N-1:1]};
                        cnt_r   <= cnt_r + ONE_CW;
                    end
                end
                ST_GAP: begin
                    gap_cnt_r <= gap_cnt_r + ONE_GW;
                end
                default: begin
                    gap_cnt_r <= gap_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Scoreboard bench for bpsk_tx_scheduler: model predicts grants, symbols, gaps and busy.
module tb_bpsk_tx_scheduler;

    localparam int HAM_N = 12;
    localparam int BCH_N = 15;
    localparam int GAP   = 2;
`ifdef BPSK_PREAMBLE_EN
    localparam int PRE_N = 4;
`else
    localparam int PRE_N = 0;
`endif

    typedef struct packed {
        logic [1:0] d;
        logic       last;
        logic       src;
    } sym_t;

    logic             clk;
    logic             rst_n;
    logic             ham_valid;
    logic [HAM_N-1:0] ham_data;
    logic             ham_ready;
    logic             bch_valid;
    logic [BCH_N-1:0] bch_data;
    logic             bch_ready;
    logic             sym_valid;
    logic [1:0]       sym_data;
    logic             sym_ready;
    logic             sym_last;
    logic             sym_src;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sym_t             exp_q[$];
    logic [HAM_N-1:0] ham_q[$];
    logic [BCH_N-1:0] bch_q[$];
    bit               grants[$];
    bit               m_rr = 1'b0;
    int               since = 1000;
    int               sym_hs = 0;
    int               rdy_mode = 0;
    bit               rand_hold = 1'b0;

    bpsk_tx_scheduler #(.HAM_N(HAM_N), .BCH_N(BCH_N), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .ham_valid(ham_valid), .ham_data(ham_data), .ham_ready(ham_ready),
        .bch_valid(bch_valid), .bch_data(bch_data), .bch_ready(bch_ready),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .sym_last(sym_last), .sym_src(sym_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wire image of one frame: optional preamble, then codeword LSB-first.
    task automatic push_frame(input bit src, input logic [BCH_N-1:0] cw);
        int n;
        sym_t e;
        n = src ? BCH_N : HAM_N;
        for (int i = 0; i < PRE_N; i++) begin
            e.d = (i % 2 == 1) ? 2'b11 : 2'b01;
            e.last = 1'b0;
            e.src = src;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.d = cw[i] ? 2'b11 : 2'b01;
            e.last = (i == n - 1);
            e.src = src;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: arbitration, gap timing, busy and symbol stream against the model.
    initial begin
        sym_t e;
        bit allowed, e_hr, e_br;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_rr = 1'b0;
                since = 1000;
            end else begin
                if (since < 1000) since++;
                allowed = (exp_q.size() == 0) && (since >= GAP + 1);
                e_hr = allowed && ham_valid && (!bch_valid || !m_rr);
                e_br = allowed && bch_valid && (!ham_valid || m_rr);
                chk("ham_ready", 32'(ham_ready), 32'(e_hr));
                chk("bch_ready", 32'(bch_ready), 32'(e_br));
                chk("busy", 32'(busy), 32'((exp_q.size() > 0) || (since >= 1 && since <= GAP)));
                chk("sym_valid", 32'(sym_valid), 32'(exp_q.size() > 0));
                if (sym_valid && exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("sym_data", 32'(sym_data), 32'(e.d));
                    chk("sym_last", 32'(sym_last), 32'(e.last));
                    chk("sym_src", 32'(sym_src), 32'(e.src));
                    if (sym_ready) begin
                        void'(exp_q.pop_front());
                        sym_hs++;
                        if (e.last) since = 0;
                    end
                end
                if (ham_valid && ham_ready) begin
                    push_frame(1'b0, {{(BCH_N-HAM_N){1'b0}}, ham_data});
                    m_rr = 1'b1;
                    grants.push_back(1'b0);
                end else if (bch_valid && bch_ready) begin
                    push_frame(1'b1, bch_data);
                    m_rr = 1'b0;
                    grants.push_back(1'b1);
                end
            end
        end
    end

    // Hamming source: holds valid until accepted, scrambles data while idle.
    initial begin
        bit hs;
        ham_valid = 1'b0;
        ham_data  = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && ham_valid && ham_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ham_valid = 1'b0;
            end else begin
                if (hs) ham_valid = 1'b0;
                if (!ham_valid) begin
                    ham_data = HAM_N'($urandom);
                    if (ham_q.size() > 0 && (!rand_hold || $urandom_range(0, 3) == 0)) begin
                        ham_data  = ham_q.pop_front();
                        ham_valid = 1'b1;
                    end
                end
            end
        end
    end

    // BCH source.
    initial begin
        bit hs;
        bch_valid = 1'b0;
        bch_data  = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && bch_valid && bch_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bch_valid = 1'b0;
            end else begin
                if (hs) bch_valid = 1'b0;
                if (!bch_valid) begin
                    bch_data = BCH_N'($urandom);
                    if (bch_q.size() > 0 && (!rand_hold || $urandom_range(0, 3) == 0)) begin
                        bch_data  = bch_q.pop_front();
                        bch_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Downstream ready: always on, 1,0,0,1 pattern, or random.
    initial begin
        logic [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: sym_ready = 1'b1;
                1: begin
                    sym_ready = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
                default: sym_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(ham_q.size() == 0 && bch_q.size() == 0 && !ham_valid && !bch_valid
                               && exp_q.size() == 0 && since > GAP)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles, %0d symbols still expected", n, exp_q.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
        chk({tag, "_sym_data"}, 32'(sym_data), 32'd0);
        chk({tag, "_sym_last"}, 32'(sym_last), 32'd0);
        chk({tag, "_sym_src"}, 32'(sym_src), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ham_ready"}, 32'(ham_ready), 32'd0);
        chk({tag, "_bch_ready"}, 32'(bch_ready), 32'd0);
    endtask

    initial begin
        int base, n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        ham_q.push_back(12'h00F);
        wait_idle(200);
        bch_q.push_back(15'h4001);
        wait_idle(200);

        grants.delete();
        ham_q.push_back(12'hA5C);
        ham_q.push_back(12'h3F1);
        bch_q.push_back(15'h1234);
        bch_q.push_back(15'h7FFE);
        wait_idle(400);
        chk("fair_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("fair_order", 32'(grants[i]), 32'(i % 2));

        rdy_mode = 1;
        ham_q.push_back(HAM_N'($urandom));
        wait_idle(400);
        rdy_mode = 0;

        base = sym_hs;
        bch_q.push_back(15'h5AA5);
        n = 0;
        while (sym_hs < base + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sym5", 32'(sym_hs >= base + 4), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        grants.delete();
        ham_q.push_back(12'h0C3);
        bch_q.push_back(15'h2468);
        wait_idle(400);
        chk("post_reset_grant", 32'(grants.size() > 0 ? grants[0] : 1'b1), 32'd0);

        rand_hold = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) ham_q.push_back(HAM_N'($urandom));
            else bch_q.push_back(BCH_N'($urandom));
        end
        wait_idle(6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpsk_tx_scheduler.md
Name: bpsk_tx_scheduler

Overview:
- Shares the BPSK symbol path between the Hamming encoder (12-bit codewords) and the BCH encoder (15-bit codewords).
- Arbitrates round-robin and latches the granted codeword.
- Serialises the codeword LSB-first as one 2-bit BPSK symbol per accepted beat: bit 0 maps to 2'b01 (+1), bit 1 maps to 2'b11 (-1).
- Inserts a programmable idle gap between frames.
- Sits between the channel encoders and the channel/noise model.

Parameters:
- HAM_N, 12: Hamming codeword width in bits; also the Hamming frame length in symbols.
- BCH_N, 15: BCH codeword width in bits; also the BCH frame length in symbols.
- GAP, 2: idle cycles after each frame's last symbol. 0 means no gap.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- ham_valid, input, 1: Hamming codeword available.
- ham_data, input, HAM_N: Hamming codeword.
- ham_ready, output, 1: Hamming codeword accepted this cycle when ham_valid is also high.
- bch_valid, input, 1: BCH codeword available.
- bch_data, input, BCH_N: BCH codeword.
- bch_ready, output, 1: BCH codeword accepted this cycle when bch_valid is also high.
- sym_valid, output, 1: sym_data is valid.
- sym_data, output, 2: BPSK symbol, 2'b01 = +1, 2'b11 = -1.
- sym_ready, input, 1: downstream accepts the symbol.
- sym_last, output, 1: marks the final symbol of a frame.
- sym_src, output, 1: source of the current frame, 0 = Hamming, 1 = BCH.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- States: IDLE, SEND, GAP (PRE added when the optional feature is compiled in).
- Reset (rst_n low, asynchronous):
  - State = IDLE; rr_ptr = 0 (Hamming preferred).
  - Shift register = 0; symbol counter = 0; gap counter = 0.
  - All outputs 0.
- IDLE, grant selection (combinational):
  - Only ham_valid high: grant Hamming.
  - Only bch_valid high: grant BCH.
  - Both high: grant the source selected by rr_ptr.
  - The granted source's ready is driven high combinationally in IDLE only. The other ready stays 0.
  - All readys are 0 in every other state.
- IDLE, on accept (valid && ready):
  - Load the codeword into a BCH_N-bit shift register, zero-extended for Hamming.
  - Load frame length (HAM_N or BCH_N); clear the symbol counter.
  - Set sym_src; set rr_ptr to the opposite of the granted source.
  - Next state = SEND.
  - First symbol appears the following cycle (1-cycle latency).
- SEND:
  - sym_valid = 1; sym_data = shreg[0] ? 2'b11 : 2'b01.
  - sym_last = 1 when the symbol counter equals length-1.
  - On sym_ready: shift right by 1 and increment the counter.
  - On sym_ready with sym_last: go to GAP if GAP > 0, else IDLE.
  - If sym_ready is low, sym_data, sym_last and sym_src hold stable.
- GAP:
  - sym_valid = 0.
  - Count GAP cycles, then return to IDLE. Arbitration is possible on the first IDLE cycle.
- Back-to-back frames:
  - With GAP = 0 and a source valid, there is exactly one IDLE cycle between frames.
- Fairness:
  - With both sources continuously valid, grants alternate H, B, H, B...
- Invalid length:
  - A length that does not match a parameter cannot occur. Counter width is clog2(BCH_N+1).
- Reset mid-frame:
  - The frame is abandoned, outputs clear immediately, and no partial frame resumes.
- Input stability:
  - Codeword inputs are sampled only on the accept cycle. Changes at any other time are ignored.

Optional Feature:
- Macro: BPSK_PREAMBLE_EN.
- When defined:
  - After accept, the block enters PRE and emits 4 preamble symbols +1, -1, +1, -1 (01, 11, 01, 11) with the same sym_ready handshake.
  - sym_src is valid during PRE; sym_last = 0 during PRE.
  - Then the block enters SEND.
  - Frame length on the wire = 4 + N.
- When undefined:
  - No PRE state; SEND is entered directly after accept.

Test Plan:
- Reset release, no valids -> busy = 0, sym_valid = 0, both readys 0 except the combinational grant once a valid rises.
- ham_data = 12'h00F, sym_ready = 1 -> 1 cycle after accept:
  - Symbols 11, 11, 11, 11, then 01 x8.
  - sym_last on the 12th symbol; sym_src = 0.
  - Then 2 gap cycles with sym_valid = 0.
- bch_data = 15'h4001, sym_ready = 1 -> symbols 11, 01 x13, 11; sym_last on the 15th symbol; sym_src = 1.
- Both valids held high for 4 frames -> grant order H, B, H, B. ham_ready and bch_ready are never high in the same cycle.
- sym_ready toggled 1,0,0,1 during SEND -> symbol held stable while stalled; no symbol dropped or duplicated; 12 symbols total.
- rst_n pulsed low at symbol 5 of a BCH frame -> outputs 0 immediately. After release, the next grant goes to Hamming (rr_ptr = 0).
- With BPSK_PREAMBLE_EN -> preamble 01, 11, 01, 11 precedes the codeword; sym_last on symbol 16 for Hamming.
